// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback result type and default sizing for the writeback stage
package wb_arbiter_pkg;
  localparam int DEF_FU_NUMBER = 4;
  localparam int DEF_WB_PORTS = 2;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int TICKET_W = 6;
  localparam int XLEN = 32;
  typedef struct packed {
    logic valid;
    logic [TICKET_W-1:0] ticket;
    logic [XLEN-1:0] data;
  } ex_update_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: single-FU result FIFO with flush; count and full come from registered state only
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  ex_update_t din,
  output ex_update_t head,
  output logic [CW-1:0] count,
  output logic full
);
  ex_update_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign wr = push && !full;
  assign rd = pop && count != '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (wr && !flush) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-FU result FIFOs drained round-robin onto WB_PORTS writeback ports.
// Optional WB_BYPASS_EN forwards a result into a free port when its FIFO is empty.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FU_NUMBER = DEF_FU_NUMBER,
  parameter int WB_PORTS = DEF_WB_PORTS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1,
  localparam int CW = $clog2(WB_PORTS + 1),
  localparam int DW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  ex_update_t fu_update [FU_NUMBER],
  input  logic flush_valid,
  output logic [FU_NUMBER-1:0] fu_ready,
  output ex_update_t wb_update [WB_PORTS],
  output logic [CW-1:0] wb_count
);
  ex_update_t head [FU_NUMBER];
  ex_update_t slot [WB_PORTS];
  logic [DW-1:0] cnt [FU_NUMBER];
  logic [FU_NUMBER-1:0] full, empty, push, gnt, byp;
  logic [PW-1:0] rr, idx, last;
  logic [CW-1:0] n;
  for (genvar g = 0; g < FU_NUMBER; g++) begin : g_fu
    assign empty[g] = cnt[g] == '0;
    assign push[g] = fu_update[g].valid && !full[g] && !byp[g];
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(flush_valid),
      .push(push[g]),
      .pop(gnt[g] && !flush_valid),
      .din(fu_update[g]),
      .head(head[g]),
      .count(cnt[g]),
      .full(full[g])
    );
  end
  assign fu_ready = ~full;
  // buffered heads are scanned first from rr; bypass candidates follow in the same circular order
  always_comb begin
    gnt = '0;
    byp = '0;
    n = '0;
    idx = '0;
    last = rr;
    for (int s = 0; s < WB_PORTS; s++) slot[s] = '0;
    for (int k = 0; k < FU_NUMBER; k++) begin
      idx = PW'((int'(rr) + k) % FU_NUMBER);
      if (!empty[idx] && int'(n) < WB_PORTS) begin
        for (int s = 0; s < WB_PORTS; s++) if (int'(n) == s) slot[s] = head[idx];
        gnt[idx] = 1'b1;
        last = idx;
        n = n + 1'b1;
      end
    end
`ifdef WB_BYPASS_EN
    for (int k = 0; k < FU_NUMBER; k++) begin
      idx = PW'((int'(rr) + k) % FU_NUMBER);
      if (empty[idx] && fu_update[idx].valid && !flush_valid && int'(n) < WB_PORTS) begin
        for (int s = 0; s < WB_PORTS; s++) if (int'(n) == s) slot[s] = fu_update[idx];
        byp[idx] = 1'b1;
        last = idx;
        n = n + 1'b1;
      end
    end
`endif
  end
  always_comb
    for (int s = 0; s < WB_PORTS; s++) wb_update[s] = flush_valid ? '0 : slot[s];
  assign wb_count = flush_valid ? '0 : n;
  always_ff @(posedge clk or posedge rst)
    if (rst) rr <= '0;
    else if (!flush_valid && n != '0) rr <= (int'(last) == FU_NUMBER - 1) ? '0 : last + 1'b1;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench for wb_arbiter against a queue-based round-robin model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int NF = DEF_FU_NUMBER;
  localparam int NP = DEF_WB_PORTS;
  localparam int D = DEF_FIFO_DEPTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_valid = 1'b0;
  ex_update_t fu_update [NF];
  ex_update_t wb_update [NP];
  logic [NF-1:0] fu_ready;
  logic [$clog2(NP+1)-1:0] wb_count;
  int checks = 0;
  int errors = 0;
  ex_update_t q [NF][$];
  logic [NF-1:0] pend = '0;
  logic [NF-1:0] byp = '0;
  int ptr = 0;

  wb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .fu_update(fu_update),
    .flush_valid(flush_valid),
    .fu_ready(fu_ready),
    .wb_update(wb_update),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: model occupancy is exactly the DUT FIFO contents at each falling edge
  initial forever begin
    int n, last, i;
    int fus [NP];
    ex_update_t ex [NP];
    logic [NF-1:0] rdy;
    @(negedge clk);
    if (rst) begin
      for (int f = 0; f < NF; f++) q[f].delete();
      ptr = 0;
      byp = '0;
      chk("rst_count", 64'(wb_count), 64'(0));
      chk("rst_ready", 64'(fu_ready), 64'({NF{1'b1}}));
    end else begin
      n = 0;
      last = ptr;
      byp = '0;
      for (int f = 0; f < NF; f++) rdy[f] = q[f].size() < D;
      if (!flush_valid) begin
        for (int k = 0; k < NF; k++) begin
          i = (ptr + k) % NF;
          if (q[i].size() > 0 && n < NP) begin
            fus[n] = i;
            ex[n] = q[i][0];
            n++;
            last = i;
          end
        end
`ifdef WB_BYPASS_EN
        for (int k = 0; k < NF; k++) begin
          i = (ptr + k) % NF;
          if (q[i].size() == 0 && fu_update[i].valid && n < NP) begin
            fus[n] = i;
            ex[n] = fu_update[i];
            byp[i] = 1'b1;
            n++;
            last = i;
          end
        end
`endif
      end
      chk("wb_count", 64'(wb_count), 64'(n));
      chk("fu_ready", 64'(fu_ready), 64'(rdy));
      for (int s = 0; s < NP; s++)
        if (s < n) chk($sformatf("slot%0d", s), 64'(wb_update[s]), 64'(ex[s]));
        else chk($sformatf("slot%0d_idle", s), 64'(wb_update[s]), 64'(0));
      for (int s = 0; s < n; s++) if (!byp[fus[s]]) void'(q[fus[s]].pop_front());
      if (n > 0) ptr = (last + 1) % NF;
      if (flush_valid) for (int f = 0; f < NF; f++) q[f].delete();
    end
  end

  // one cycle of stimulus: commit last cycle's accepted pushes, then drive new inputs
  task automatic drive_cycle(input logic [NF-1:0] vm, input logic fl, input int dfu,
                             input logic [XLEN-1:0] dd, input logic [TICKET_W-1:0] dt);
    logic [NF-1:0] hold;
    @(posedge clk);
    for (int i = 0; i < NF; i++) begin
      if (pend[i] && !flush_valid && !byp[i]) q[i].push_back(fu_update[i]);
      hold[i] = fu_update[i].valid && !pend[i] && !flush_valid;
    end
    #1;
    flush_valid = fl;
    for (int i = 0; i < NF; i++) begin
      if (!hold[i]) begin
        fu_update[i] = '0;
        if (vm[i]) begin
          fu_update[i].valid = 1'b1;
          fu_update[i].ticket = (i == dfu) ? dt : TICKET_W'($urandom);
          fu_update[i].data = (i == dfu) ? dd : $urandom;
        end
      end
      pend[i] = fu_update[i].valid && q[i].size() < D;
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) drive_cycle('0, 1'b0, -1, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < NF; i++) fu_update[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    drive_cycle(4'b0100, 1'b0, 2, 32'hDEAD_BEEF, 6'd3);
    idle(3);
    drive_cycle(4'b1000, 1'b0, -1, '0, '0);
    idle(2);
    drive_cycle(4'b1111, 1'b0, -1, '0, '0);
    idle(3);
    repeat (6) drive_cycle(4'b1111, 1'b0, -1, '0, '0);
    idle(4);
    repeat (3) drive_cycle(4'b1111, 1'b0, -1, '0, '0);
    drive_cycle(4'b1111, 1'b1, -1, '0, '0);
    idle(1);
    drive_cycle(4'b0100, 1'b0, 2, 32'h1234_5678, 6'd9);
    idle(3);
    repeat (1500) drive_cycle(NF'($urandom), $urandom_range(0, 31) == 0, -1, '0, '0);
    repeat (4) drive_cycle(4'b1111, 1'b0, -1, '0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(wb_count), 64'(0));
    for (int s = 0; s < NP; s++) chk($sformatf("async_rst_valid%0d", s), 64'(wb_update[s].valid), 64'(0));
    chk("async_rst_ready", 64'(fu_ready), 64'({NF{1'b1}}));
    for (int i = 0; i < NF; i++) fu_update[i] = '0;
    flush_valid = 1'b0;
    pend = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    drive_cycle(4'b0100, 1'b0, 2, 32'hCAFE_F00D, 6'd5);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
